pulse_pattern_generator: RTL
============================

# pulse_pattern_generator

Multi-channel programmable pulse/PWM generator: each of `CHANNELS` independent channels produces a periodic registered waveform with runtime-programmable period and high time, plus a one-cycle end-of-period strobe. It is the parametrised successor to the fixed-delay single-pulse generator. It sits beside the timing and LED/IO logic as the common source of ticks, strobes and duty-cycle outputs. Configuration changes are double-buffered and take effect only at a period boundary, so outputs never glitch mid-period.

## Interface

- `CHANNELS`, 4: number of independent channels (1..16).
- `CNT_WIDTH`, 16: counter width; period range is 1..2^CNT_WIDTH cycles.
- `DEFAULT_PERIOD_M1`, 0: reset value of every channel's period-minus-one.
- `DEFAULT_HIGH`, 1: reset value of every channel's high-cycle count.

Ports:

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `enable`  in  CHANNELS  per-channel run enable, sampled each edge.
- `cfg_valid`  in  1  config write request.
- `cfg_ready`  out  1  config write can be accepted.
- `cfg_channel`  in  $clog2(CHANNELS) (min 1)  target channel.
- `cfg_period_m1`  in  CNT_WIDTH  new period minus one.
- `cfg_high`  in  CNT_WIDTH  new high-cycle count.
- `out`  out  CHANNELS  registered waveform per channel.
- `wrap`  out  CHANNELS  registered one-cycle end-of-period strobe.

## Operation

- Per-channel state:
  - counter `cnt` (CNT_WIDTH);
  - active `P_m1`, `H`;
  - shadow `P_m1_s`, `H_s`;
  - `pending` flag.
- At each edge, using pre-edge values, for channel i with enable `en`:
  - `out[i]` <= en && (cnt < H).
  - `wrap[i]` <= en && (cnt == P_m1).
  - `cnt` <= !en ? 0 : (cnt == P_m1 ? 0 : cnt + 1). Counter arithmetic wraps modulo 2^CNT_WIDTH only via the P_m1 compare; no other overflow exists.
- Duty rules:
  - H = 0: `out` constant low.
  - H > P_m1: `out` constant high while enabled.
  - P_m1 = 0, H ≥ 1: `out` and `wrap` high every enabled cycle.
  - Constant high is unreachable when P_m1 = 2^CNT_WIDTH-1; this is accepted as a limitation.
- Config handshake:
  - `cfg_ready` = !pending[cfg_channel], combinational.
  - If `cfg_channel` ≥ CHANNELS: `cfg_ready` = 1 and the write is dropped.
  - A write is accepted on an edge with `cfg_valid && cfg_ready`. The edge loads the shadow registers and sets `pending`.
- Apply: at any edge where pending && (!en || cnt == P_m1), the shadow values are copied to active and `pending` clears. The new values govern evaluation from the next edge onward. An accept and an apply can never coincide on one channel, because `ready` is low while pending.
- Disable mid-period: the next edge forces `cnt` = 0, `out` = 0, `wrap` = 0 and applies any pending config. Re-enable restarts the period from cnt = 0.

## Timing

- Reset (async assert, any time, including mid-period or mid-handshake):
  - `out` = 0, `wrap` = 0, `cnt` = 0, `pending` = 0;
  - active and shadow registers = DEFAULT_PERIOD_M1 / DEFAULT_HIGH;
  - `cfg_ready` = 1.
- Reset deassertion is synchronised externally; first active edge is the first edge with `rst_n` high.
- Enable latency: with `enable` high before edge k, `out` rises after edge k (cnt = 0 < H). `wrap` first pulses after edge k+P_m1.
- `out`/`wrap` are registered; no combinational path from inputs to `out`/`wrap`. `cfg_ready` depends combinationally on `cfg_channel`.
- Config latency: a config accepted at edge a on an enabled channel takes effect at the first boundary edge b ≥ a+1 where cnt == P_m1 (pre-edge). The waveform after b uses the new values. `cfg_ready` returns high after b.
- Channels are fully independent; no cross-channel ordering.

## Test plan

- Reset defaults, CHANNELS = 1, P_m1 = 0, H = 1, enable held high → `out` = 1 and `wrap` = 1 every cycle after the first edge, matching the legacy DELAY = 1 behaviour.
- Ch0 P_m1 = 3, H = 1, enable before edge 0 → `out` high after edges 0, 4, 8; `wrap` high after edges 3, 7, 11; all other cycles low.
- Ch1 enabled with P_m1 = 9, H = 3; write P_m1 = 4, H = 5 at cnt = 2:
  - `cfg_ready` for ch1 stays low until the boundary edge;
  - the old 10-cycle period completes intact;
  - afterwards `out` is constant high with `wrap` every 5 cycles.
- H = 0 on ch2 → `out` never rises while `wrap` still pulses every P_m1+1 cycles. Drop enable mid-period → `out`/`wrap` low on the next edge. Re-enable → restart at cnt = 0.
- Assert `rst_n` low mid-period with ch3 pending → all outputs 0 immediately and `pending` cleared. After release, ch3 runs with default period and high, not the pending values.
- Write to `cfg_channel` = CHANNELS (out of range) → accepted with `ready` high; no channel's waveform changes.

Source files
------------

// File: rtl/pulse_pattern_generator.sv
// Multi-channel programmable pulse/PWM generator with per-channel period, high time
// and end-of-period strobe; config writes are shadowed and applied at period boundaries.
module pulse_pattern_generator #(
   parameter int          CHANNELS          = 4,
   parameter int          CNT_WIDTH         = 16,
   parameter int unsigned DEFAULT_PERIOD_M1 = 0,
   parameter int unsigned DEFAULT_HIGH      = 1,
   localparam int         CH_W              = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [CHANNELS-1:0]  enable,
   input  logic                 cfg_valid,
   output logic                 cfg_ready,
   input  logic [CH_W-1:0]      cfg_channel,
   input  logic [CNT_WIDTH-1:0] cfg_period_m1,
   input  logic [CNT_WIDTH-1:0] cfg_high,
   output logic [CHANNELS-1:0]  out,
   output logic [CHANNELS-1:0]  wrap
);

   localparam logic [CNT_WIDTH-1:0] RST_PM1  = CNT_WIDTH'(DEFAULT_PERIOD_M1);
   localparam logic [CNT_WIDTH-1:0] RST_HIGH = CNT_WIDTH'(DEFAULT_HIGH);

   logic [CHANNELS-1:0][CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic [CHANNELS-1:0][CNT_WIDTH-1:0] pm1_q, pm1_d;
   logic [CHANNELS-1:0][CNT_WIDTH-1:0] high_q, high_d;
   logic [CHANNELS-1:0][CNT_WIDTH-1:0] pm1_s_q, pm1_s_d;
   logic [CHANNELS-1:0][CNT_WIDTH-1:0] high_s_q, high_s_d;
   logic [CHANNELS-1:0]                pending_q, pending_d;
   logic [CHANNELS-1:0]                out_q, out_d;
   logic [CHANNELS-1:0]                wrap_q, wrap_d;
   logic                               in_range;
   logic                               accept;

   // Handshake: a write transfers on an edge where cfg_valid && cfg_ready.
   // Out-of-range channels always report ready and the write is discarded.
   assign in_range = ({1'b0, cfg_channel} < (CH_W + 1)'(CHANNELS));

   always_comb begin
      cfg_ready = 1'b1;
      if (in_range) cfg_ready = !pending_q[cfg_channel];
   end

   assign accept = cfg_valid && cfg_ready && in_range;
   assign out    = out_q;
   assign wrap   = wrap_q;

   always_comb begin
      cnt_d     = cnt_q;
      pm1_d     = pm1_q;
      high_d    = high_q;
      pm1_s_d   = pm1_s_q;
      high_s_d  = high_s_q;
      pending_d = pending_q;
      out_d     = '0;
      wrap_d    = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         out_d[i]  = enable[i] && (cnt_q[i] < high_q[i]);
         wrap_d[i] = enable[i] && (cnt_q[i] == pm1_q[i]);
         if (!enable[i] || (cnt_q[i] == pm1_q[i])) cnt_d[i] = '0;
         else                                      cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
         // Apply at a boundary (or while idle); ready is low while pending, so never both.
         if (pending_q[i] && (!enable[i] || (cnt_q[i] == pm1_q[i]))) begin
            pm1_d[i]     = pm1_s_q[i];
            high_d[i]    = high_s_q[i];
            pending_d[i] = 1'b0;
         end else if (accept && (cfg_channel == CH_W'(i))) begin
            pm1_s_d[i]   = cfg_period_m1;
            high_s_d[i]  = cfg_high;
            pending_d[i] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q     <= '0;
         pm1_q     <= {CHANNELS{RST_PM1}};
         high_q    <= {CHANNELS{RST_HIGH}};
         pm1_s_q   <= {CHANNELS{RST_PM1}};
         high_s_q  <= {CHANNELS{RST_HIGH}};
         pending_q <= '0;
         out_q     <= '0;
         wrap_q    <= '0;
      end else begin
         cnt_q     <= cnt_d;
         pm1_q     <= pm1_d;
         high_q    <= high_d;
         pm1_s_q   <= pm1_s_d;
         high_s_q  <= high_s_d;
         pending_q <= pending_d;
         out_q     <= out_d;
         wrap_q    <= wrap_d;
      end
   end

endmodule
